// File: rtl/video_tg_param.sv
// Parametrised video timing generator: counters, composite sync, blanking, burst gate, XHD/XVD strobes, field flag.
// Optional genlock to an external XHD is enabled by defining VIDEO_TG_PARAM_GENLOCK_EN.
module video_tg_param #(
   parameter int C_HCTR_W     = 11,
   parameter int C_VCTR_W     = 10,
   parameter int C_H_TOT      = 910,
   parameter int C_V_TOT      = 525,
   parameter int C_HSYNC_LEN  = 67,
   parameter int C_HBLK_END   = 150,
   parameter int C_HFP_LEN    = 20,
   parameter int C_BURST_ST   = 76,
   parameter int C_BURST_LEN  = 36,
   parameter int C_VSYNC_ST   = 3,
   parameter int C_VSYNC_LEN  = 3,
   parameter int C_VBLK_LINES = 20
) (
   input  logic                CK_i,
   input  logic                SR_i,
   input  logic                CK_EE_i,
   input  logic                INTERLACE_i,
`ifdef VIDEO_TG_PARAM_GENLOCK_EN
   input  logic                XHD_EXT_i,
`endif
   output logic                XSYNC_o,
   output logic                BLANK_o,
   output logic                BURST_o,
   output logic                XHD_o,
   output logic                XVD_o,
   output logic                FIELD_o,
   output logic [C_HCTR_W-1:0] HCTRs_o,
   output logic [C_VCTR_W-1:0] VCTRs_o
);

   localparam int H_LAST      = C_H_TOT - 1;
   localparam int V_LAST      = C_V_TOT - 1;
   localparam int V_HALF      = (C_V_TOT + 1) / 2;
   localparam int V_PROG_LAST = (C_V_TOT - 1) / 2 - 1;
   localparam int SERR_ST     = C_H_TOT - C_HSYNC_LEN;
   localparam int HFP_ST      = C_H_TOT - C_HFP_LEN;

   logic [C_HCTR_W-1:0] hctr_q, hctr_d;
   logic [C_VCTR_W-1:0] vctr_q, vctr_d;
   logic ilace_q, ilace_d;
   logic xsync_q, xsync_d;
   logic blank_q, blank_d;
   logic burst_q, burst_d;
   logic xhd_q, xhd_d;
   logic xvd_q, xvd_d;
   logic field_q, field_d;
   logic ext_d1_q, ext_d1_d;

   logic [31:0] h32, v32, fl32;
   logic in_f1, line_end, field_last, frame_last, hsync, vsync_line, wrap, ext_fall;

   // Decode runs on 32-bit zero-extended counters so compares see full parameter values.
   always_comb begin
      h32        = 32'(hctr_q);
      v32        = 32'(vctr_q);
      in_f1      = ilace_q && (v32 >= V_HALF);
      fl32       = in_f1 ? (v32 - V_HALF) : v32;
      line_end   = (h32 == H_LAST);
      field_last = ilace_q ? ((v32 == V_HALF - 1) || (v32 == V_LAST)) : (v32 == V_PROG_LAST);
      frame_last = ilace_q ? (v32 == V_LAST) : (v32 == V_PROG_LAST);
      hsync      = (h32 < C_HSYNC_LEN);
      vsync_line = (fl32 >= C_VSYNC_ST) && (fl32 < C_VSYNC_ST + C_VSYNC_LEN);
`ifdef VIDEO_TG_PARAM_GENLOCK_EN
      ext_fall   = ext_d1_q && !XHD_EXT_i;
      ext_d1_d   = CK_EE_i ? XHD_EXT_i : ext_d1_q;
`else
      ext_fall   = 1'b0;
      ext_d1_d   = ext_d1_q;
`endif
      wrap       = line_end || ext_fall;

      hctr_d  = hctr_q;
      vctr_d  = vctr_q;
      ilace_d = ilace_q;
      xsync_d = xsync_q;
      blank_d = blank_q;
      burst_d = burst_q;
      xhd_d   = xhd_q;
      xvd_d   = xvd_q;
      field_d = field_q;

      if (CK_EE_i) begin
         // Vsync lines are held low except for the serration tail of each line.
         xsync_d = vsync_line ? (h32 >= SERR_ST) : !hsync;
         blank_d = (h32 < C_HBLK_END) || (h32 >= HFP_ST) || (fl32 < C_VBLK_LINES);
         burst_d = (h32 >= C_BURST_ST) && (h32 < C_BURST_ST + C_BURST_LEN) && !vsync_line;
         xhd_d   = !line_end;
         xvd_d   = !(line_end && field_last);
         field_d = in_f1;
         if (wrap) begin
            hctr_d = '0;
            if (frame_last) begin
               vctr_d  = '0;
               ilace_d = INTERLACE_i;
            end else begin
               vctr_d = vctr_q + 1'b1;
            end
         end else begin
            hctr_d = hctr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CK_i) begin
      if (SR_i) begin
         hctr_q   <= '0;
         vctr_q   <= '0;
         ilace_q  <= INTERLACE_i;
         xsync_q  <= 1'b1;
         blank_q  <= 1'b1;
         burst_q  <= 1'b0;
         xhd_q    <= 1'b1;
         xvd_q    <= 1'b1;
         field_q  <= 1'b0;
         ext_d1_q <= 1'b1;
      end else begin
         hctr_q   <= hctr_d;
         vctr_q   <= vctr_d;
         ilace_q  <= ilace_d;
         xsync_q  <= xsync_d;
         blank_q  <= blank_d;
         burst_q  <= burst_d;
         xhd_q    <= xhd_d;
         xvd_q    <= xvd_d;
         field_q  <= field_d;
         ext_d1_q <= ext_d1_d;
      end
   end

   assign XSYNC_o = xsync_q;
   assign BLANK_o = blank_q;
   assign BURST_o = burst_q;
   assign XHD_o   = xhd_q;
   assign XVD_o   = xvd_q;
   assign FIELD_o = field_q;
   assign HCTRs_o = hctr_q;
   assign VCTRs_o = vctr_q;

endmodule
